// File: rtl/router_pkg.sv
// Shared types and header-field helpers for the router output path.
package router_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 6;
  localparam int unsigned ADDR_W = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR_WAIT,
    S_BODY,
    S_DRAIN
  } drain_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic              parity_err;
  } beat_t;

  function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
    return hdr[DATA_W-1:ADDR_W];
  endfunction

  function automatic logic [ADDR_W-1:0] hdr_addr(input logic [DATA_W-1:0] hdr);
    return hdr[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/router_skid_buf.sv
// Two-entry valid/ready output buffer with flush and occupancy report.
module router_skid_buf
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       pop_ready,
  output logic       out_valid,
  output beat_t      out_beat,
  output logic [1:0] occupancy
);

  beat_t      head;
  beat_t      tail;
  logic [1:0] count;
  logic       pop;
  logic       push_ok;

  assign pop       = pop_ready && (count != 2'd0);
  assign push_ok   = push && ((count != 2'd2) || pop);
  assign out_valid = (count != 2'd0);
  assign out_beat  = head;
  assign occupancy = count;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      case ({push_ok, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_beat;
          else               tail <= push_beat;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= push_beat;
          end else begin
            head <= tail;
            tail <= push_beat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/router_out_drain.sv
// Drains whole packets from an output-port FIFO onto a valid/ready link,
// checking XOR parity and abandoning the packet on a destination timeout.
module router_out_drain
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT = 30
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              fifo_soft_reset,
  input  logic              ready_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              sop,
  output logic              eop,
  output logic              parity_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  drain_state_t      state;
  drain_state_t      state_next;
  logic [LEN_W:0]    remaining;
  logic              inflight;
  logic              inflight_last;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  stall_cnt;

  logic [1:0]        occ;
  logic [2:0]        used;
  logic              pop;
  logic              timeout;
  logic              credit_ok;
  logic              push;
  beat_t             push_beat;
  beat_t             head;

  assign pop     = valid_out && ready_in;
  assign timeout = (stall_cnt == CNT_W'(TIMEOUT)) && !ready_in;
  assign used    = 3'(occ) + 3'(inflight);
  // A beat leaving this cycle frees a slot in time for a read issued now,
  // which is what lets the path run at one byte per cycle.
  assign credit_ok       = pop ? (used < 3'd3) : (used < 3'd2);
  assign fifo_soft_reset = timeout;

  always_comb begin
    state_next = state;
    fifo_rd_en = 1'b0;
    push       = 1'b0;
    push_beat  = '0;
    case (state)
      S_IDLE: begin
        fifo_rd_en = !fifo_empty;
        if (!fifo_empty) state_next = S_HDR_WAIT;
      end
      S_HDR_WAIT: begin
        push           = 1'b1;
        push_beat.data = fifo_data;
        push_beat.sop  = 1'b1;
        state_next     = S_BODY;
      end
      S_BODY: begin
        fifo_rd_en           = (remaining != '0) && !fifo_empty && credit_ok;
        push                 = inflight;
        push_beat.data       = fifo_data;
        push_beat.eop        = inflight_last;
        push_beat.parity_err = inflight_last && (fifo_data != acc);
        if ((remaining == '0) && !inflight) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if ((occ == 2'd0) || (pop && (occ == 2'd1))) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (timeout) fifo_rd_en = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset || timeout) begin
      state         <= S_IDLE;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      acc           <= '0;
      stall_cnt     <= '0;
    end else begin
      state         <= state_next;
      inflight      <= fifo_rd_en && (state == S_BODY);
      inflight_last <= fifo_rd_en && (state == S_BODY) && (remaining == (LEN_W+1)'(1));
      stall_cnt     <= (valid_out && !ready_in) ? stall_cnt + CNT_W'(1) : '0;
      if (state == S_HDR_WAIT) begin
        remaining <= (LEN_W+1)'(hdr_len(fifo_data)) + (LEN_W+1)'(1);
        acc       <= fifo_data;
      end else if (state == S_BODY) begin
        if (fifo_rd_en) remaining <= remaining - (LEN_W+1)'(1);
        if (inflight && !inflight_last) acc <= acc ^ fifo_data;
      end
    end
  end

  router_skid_buf u_buf (
    .clock     (clock),
    .reset     (reset),
    .flush     (timeout),
    .push      (push),
    .push_beat (push_beat),
    .pop_ready (ready_in),
    .out_valid (valid_out),
    .out_beat  (head),
    .occupancy (occ)
  );

  assign data_out   = head.data;
  assign sop        = head.sop;
  assign eop        = head.eop;
  assign parity_err = head.parity_err;

endmodule

// File: tb/tb_router_out_drain.sv
// Directed bench for router_out_drain with a behavioural port FIFO.
module tb_router_out_drain;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       perr;
  } tbeat_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd_en;
  logic       fifo_soft_reset;
  logic       ready_in = 1'b0;
  logic       valid_out;
  logic [7:0] data_out;
  logic       sop;
  logic       eop;
  logic       parity_err;

  logic        stall_empty = 1'b0;
  logic [7:0]  fifo_mem [0:1023];
  int unsigned loaded = 0;
  int unsigned popped = 0;

  tbeat_t      got[$];
  int unsigned got_cyc[$];
  tbeat_t      exp[$];
  int unsigned cyc = 0;
  int unsigned rd_viol = 0;
  int unsigned sr_count = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  router_out_drain #(.TIMEOUT(30)) dut (
    .clock           (clock),
    .reset           (reset),
    .fifo_empty      (fifo_empty),
    .fifo_data       (fifo_data),
    .fifo_rd_en      (fifo_rd_en),
    .fifo_soft_reset (fifo_soft_reset),
    .ready_in        (ready_in),
    .valid_out       (valid_out),
    .data_out        (data_out),
    .sop             (sop),
    .eop             (eop),
    .parity_err      (parity_err)
  );

  always #5 clock = ~clock;

  assign fifo_empty = stall_empty || (loaded == popped);

  always @(posedge clock) begin
    if (reset || fifo_soft_reset) begin
      popped <= loaded;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= fifo_mem[popped[9:0]];
      popped    <= popped + 1;
    end
  end

  function automatic tbeat_t mk(input logic [7:0] d, input logic s, input logic e, input logic p);
    tbeat_t b;
    b.data = d; b.sop = s; b.eop = e; b.perr = p;
    return b;
  endfunction

  task automatic step(input logic rdy, input logic emp);
    @(negedge clock);
    ready_in    = rdy;
    stall_empty = emp;
    #1;
    cyc++;
    if (fifo_rd_en && fifo_empty) rd_viol++;
    if (fifo_soft_reset) sr_count++;
    if (valid_out && ready_in && !reset) begin
      got.push_back(mk(data_out, sop, eop, parity_err));
      got_cyc.push_back(cyc);
    end
  endtask

  task automatic add_byte(input logic [7:0] b);
    fifo_mem[loaded[9:0]] = b;
    loaded = loaded + 1;
  endtask

  task automatic add_pkt(input logic [7:0] hdr, input logic corrupt);
    logic [7:0] par;
    logic [7:0] b;
    par = hdr;
    add_byte(hdr);
    exp.push_back(mk(hdr, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < int'(hdr[7:2]); i++) begin
      b = 8'($urandom);
      par ^= b;
      add_byte(b);
      exp.push_back(mk(b, 1'b0, 1'b0, 1'b0));
    end
    if (corrupt) par = ~par;
    add_byte(par);
    exp.push_back(mk(par, 1'b0, 1'b1, corrupt));
  endtask

  task automatic run_until_done(input int unsigned budget, input logic rnd);
    for (int i = 0; i < int'(budget) && got.size() < exp.size(); i++) begin
      if (rnd) step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      else     step(1'b1, 1'b0);
    end
    repeat (4) step(1'b1, 1'b0);
  endtask

  task automatic clear_sb();
    got.delete();
    got_cyc.delete();
    exp.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    n_cmp++;
    if ({fifo_rd_en, fifo_soft_reset, valid_out, data_out, sop, eop, parity_err} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rd=%b sr=%b v=%b d=%h sop=%b eop=%b perr=%b, want all 0",
               fifo_rd_en, fifo_soft_reset, valid_out, data_out, sop, eop, parity_err);
    end
    @(negedge clock);
    reset = 1'b0;
    step(1'b0, 1'b0);
    n_cmp++;
    if ({fifo_rd_en, valid_out} !== 2'b00) begin
      n_bad++;
      $display("FAIL post_reset_idle: got rd=%b v=%b, want 0 0", fifo_rd_en, valid_out);
    end
  endtask

  task automatic test_stream();
    int unsigned gaps;
    clear_sb();
    add_pkt(8'h39, 1'b0);
    #1;
    n_cmp++;
    if (fifo_rd_en !== 1'b1) begin
      n_bad++; $display("FAIL hdr_rd_en: got %b want 1", fifo_rd_en);
    end
    step(1'b1, 1'b0);
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_bad++; $display("FAIL hdr_lat_t1: valid_out got %b want 0", valid_out);
    end
    step(1'b1, 1'b0);
    n_cmp++;
    if ({valid_out, sop, data_out} !== {1'b1, 1'b1, 8'h39}) begin
      n_bad++; $display("FAIL hdr_lat_t2: got v=%b sop=%b d=%h want 1 1 39", valid_out, sop, data_out);
    end
    run_until_done(60, 1'b0);
    n_cmp++;
    if (got.size() !== 16) begin
      n_bad++; $display("FAIL stream_count: got %0d beats want 16", got.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin
        n_bad++; $display("FAIL stream_beat%0d: got %h want %h", i, got[i], exp[i]);
      end
    end
    gaps = 0;
    for (int i = 2; i < got_cyc.size(); i++)
      if (got_cyc[i] != got_cyc[i-1] + 1) gaps++;
    n_cmp++;
    if (gaps !== 0) begin
      n_bad++; $display("FAIL stream_gaps: got %0d gaps want 0", gaps);
    end
  endtask

  task automatic test_parity_err();
    clear_sb();
    add_pkt(8'h39, 1'b1);
    add_pkt(8'h0D, 1'b0);
    run_until_done(120, 1'b0);
    n_cmp++;
    if (got.size() !== exp.size()) begin
      n_bad++; $display("FAIL perr_count: got %0d beats want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin
        n_bad++; $display("FAIL perr_beat%0d: got %h want %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_len0();
    clear_sb();
    add_byte(8'h02);
    add_byte(8'h02);
    exp.push_back(mk(8'h02, 1'b1, 1'b0, 1'b0));
    exp.push_back(mk(8'h02, 1'b0, 1'b1, 1'b0));
    run_until_done(20, 1'b0);
    n_cmp++;
    if (got.size() !== 2) begin
      n_bad++; $display("FAIL len0_count: got %0d beats want 2", got.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin
        n_bad++; $display("FAIL len0_beat%0d: got %h want %h", i, got[i], exp[i]);
      end
    end
  endtask

  // Packet 08 A5 3C 91: len 2, parity 08^A5^3C = 91.
  task automatic load_short_pkt();
    add_byte(8'h08); add_byte(8'hA5); add_byte(8'h3C); add_byte(8'h91);
    exp.push_back(mk(8'h08, 1'b1, 1'b0, 1'b0));
    exp.push_back(mk(8'hA5, 1'b0, 1'b0, 1'b0));
    exp.push_back(mk(8'h3C, 1'b0, 1'b0, 1'b0));
    exp.push_back(mk(8'h91, 1'b0, 1'b1, 1'b0));
  endtask

  task automatic test_stall_29();
    int unsigned hold_bad;
    int unsigned waited;
    clear_sb();
    sr_count = 0;
    hold_bad = 0;
    load_short_pkt();
    waited = 0;
    do begin
      step(1'b0, 1'b0);
      waited++;
    end while (!valid_out && waited < 10);
    n_cmp++;
    if (valid_out !== 1'b1) begin
      n_bad++; $display("FAIL stall29_hdr: valid_out got %b want 1 within 10 cycles", valid_out);
    end
    repeat (28) begin
      step(1'b0, 1'b0);
      if (!valid_out || data_out !== 8'h08 || sop !== 1'b1) hold_bad++;
    end
    n_cmp++;
    if (hold_bad !== 0) begin
      n_bad++; $display("FAIL stall29_hold: got %0d changed cycles want 0", hold_bad);
    end
    run_until_done(30, 1'b0);
    n_cmp++;
    if (sr_count !== 0) begin
      n_bad++; $display("FAIL stall29_no_sr: got %0d pulses want 0", sr_count);
    end
    n_cmp++;
    if (got.size() !== 4) begin
      n_bad++; $display("FAIL stall29_count: got %0d beats want 4", got.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin
        n_bad++; $display("FAIL stall29_beat%0d: got %h want %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_timeout_30();
    int unsigned waited;
    clear_sb();
    sr_count = 0;
    load_short_pkt();
    waited = 0;
    do begin
      step(1'b0, 1'b0);
      waited++;
    end while (!valid_out && waited < 10);
    repeat (29) step(1'b0, 1'b0);
    n_cmp++;
    if (sr_count !== 0) begin
      n_bad++; $display("FAIL to30_early: got %0d pulses before stall cycle 30 want 0", sr_count);
    end
    step(1'b0, 1'b0);
    n_cmp++;
    if (fifo_soft_reset !== 1'b1) begin
      n_bad++; $display("FAIL to30_pulse: soft_reset got %b want 1", fifo_soft_reset);
    end
    step(1'b0, 1'b0);
    n_cmp++;
    if ({valid_out, fifo_soft_reset} !== 2'b00) begin
      n_bad++; $display("FAIL to30_flush: got v=%b sr=%b want 0 0", valid_out, fifo_soft_reset);
    end
    repeat (3) step(1'b1, 1'b0);
    n_cmp++;
    if (got.size() !== 0 || sr_count !== 1 || fifo_rd_en !== 1'b0) begin
      n_bad++; $display("FAIL to30_idle: got beats=%0d pulses=%0d rd=%b want 0 1 0",
                        got.size(), sr_count, fifo_rd_en);
    end
  endtask

  task automatic test_back_to_back();
    clear_sb();
    sr_count = 0;
    rd_viol = 0;
    add_pkt(8'h15, 1'b0);
    add_pkt(8'h22, 1'b0);
    add_pkt(8'h0A, 1'b0);
    run_until_done(500, 1'b1);
    n_cmp++;
    if (got.size() !== exp.size()) begin
      n_bad++; $display("FAIL b2b_count: got %0d beats want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin
        n_bad++; $display("FAIL b2b_beat%0d: got %h want %h", i, got[i], exp[i]);
      end
    end
    n_cmp++;
    if (rd_viol !== 0 || sr_count !== 0) begin
      n_bad++; $display("FAIL b2b_rd_empty: got %0d reads while empty, %0d pulses, want 0 0",
                        rd_viol, sr_count);
    end
  endtask

  task automatic test_reset_mid();
    clear_sb();
    add_pkt(8'h1C, 1'b0);
    for (int i = 0; i < 40 && got.size() < 5; i++) step(1'b1, 1'b0);
    n_cmp++;
    if (got.size() !== 5) begin
      n_bad++; $display("FAIL rmid_reach: got %0d beats want 5", got.size());
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (data_out !== exp[5].data) begin
      n_bad++; $display("FAIL rmid_byte5: got %h want %h", data_out, exp[5].data);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({fifo_rd_en, fifo_soft_reset, valid_out, data_out, sop, eop, parity_err} !== 14'd0) begin
      n_bad++;
      $display("FAIL rmid_outputs: got rd=%b sr=%b v=%b d=%h sop=%b eop=%b perr=%b, want all 0",
               fifo_rd_en, fifo_soft_reset, valid_out, data_out, sop, eop, parity_err);
    end
    clear_sb();
    // 10 11 22 33 44, parity 10^11^22^33^44 = 54
    add_byte(8'h10); add_byte(8'h11); add_byte(8'h22); add_byte(8'h33); add_byte(8'h44);
    add_byte(8'h54);
    exp.push_back(mk(8'h10, 1'b1, 1'b0, 1'b0));
    exp.push_back(mk(8'h11, 1'b0, 1'b0, 1'b0));
    exp.push_back(mk(8'h22, 1'b0, 1'b0, 1'b0));
    exp.push_back(mk(8'h33, 1'b0, 1'b0, 1'b0));
    exp.push_back(mk(8'h44, 1'b0, 1'b0, 1'b0));
    exp.push_back(mk(8'h54, 1'b0, 1'b1, 1'b0));
    run_until_done(40, 1'b0);
    n_cmp++;
    if (got.size() !== 6) begin
      n_bad++; $display("FAIL rmid_clean_count: got %0d beats want 6", got.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin
        n_bad++; $display("FAIL rmid_clean_beat%0d: got %h want %h", i, got[i], exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_parity_err();
    test_len0();
    test_stall_29();
    test_timeout_30();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "time limit");
  end

endmodule
